// File: rtl/alu_lockstep_pipe.sv
// alu_lockstep_pipe: two-lane pipelined ALU with lockstep XOR comparison and error logging
module alu_lockstep_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       sel0,
  input  logic [2:0]       sel1,
  input  logic             lockstep,
  input  logic             fault_inj,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out0,
  output logic [WIDTH-1:0] alu_out1,
  output logic             carry0,
  output logic             carry1,
  output logic [WIDTH-1:0] diff,
  output logic             carry_diff,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);
  logic             v1, fi_r, ls_r;
  logic [WIDTH-1:0] a0_r, b0_r, a1_r, b1_r, o1, d;
  logic [2:0]       s0_r, s1_r;
  logic [WIDTH:0]   r0, r1;
  logic             cd;

  function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] s);
    alu = s == 3'd0 ? {1'b0, a} + {1'b0, b} :
          s == 3'd1 ? {1'b0, a} - {1'b0, b} :
          s == 3'd2 ? {1'b0, a & b} :
          s == 3'd3 ? {1'b0, a | b} :
          s == 3'd4 ? {1'b0, a ^ b} :
          s == 3'd5 ? {a[WIDTH-1], a[WIDTH-2:0], 1'b0} :
          s == 3'd6 ? {a[0], 1'b0, a[WIDTH-1:1]} :
                      {a < b, a < b ? b : a};
  endfunction

  assign r0 = alu(a0_r, b0_r, s0_r);
  assign r1 = alu(a1_r, b1_r, s1_r);
  assign o1 = r1[WIDTH-1:0] ^ {{(WIDTH-1){1'b0}}, fi_r};
  assign d  = r0[WIDTH-1:0] ^ o1;
  assign cd = r0[WIDTH] ^ r1[WIDTH];

  // stage 1: capture operand set, steering lane 1 onto lane 0 inputs in lockstep
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      v1   <= 1'b0;
      a0_r <= '0;
      b0_r <= '0;
      a1_r <= '0;
      b1_r <= '0;
      s0_r <= '0;
      s1_r <= '0;
      fi_r <= 1'b0;
      ls_r <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a0_r <= a0;
        b0_r <= b0;
        s0_r <= sel0;
        a1_r <= lockstep ? a0 : a1;
        b1_r <= lockstep ? b0 : b1;
        s1_r <= lockstep ? sel0 : sel1;
        fi_r <= fault_inj;
        ls_r <= lockstep;
      end
    end
  end

  // stage 2: register lane results and comparison; results hold between valid sets
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_valid  <= 1'b0;
      mismatch   <= 1'b0;
      alu_out0   <= '0;
      alu_out1   <= '0;
      carry0     <= 1'b0;
      carry1     <= 1'b0;
      diff       <= '0;
      carry_diff <= 1'b0;
    end else begin
      out_valid <= v1;
      mismatch  <= v1 & ls_r & ((|d) | cd);
      if (v1) begin
        alu_out0   <= r0[WIDTH-1:0];
        alu_out1   <= o1;
        carry0     <= r0[WIDTH];
        carry1     <= r1[WIDTH];
        diff       <= d;
        carry_diff <= cd;
      end
    end
  end

  // error log follows the registered pulse, so a clear seen alongside a pulse discards it
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr_err) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (mismatch) begin
      err_sticky <= 1'b1;
      if (err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_lockstep_pipe.sv
// tb_alu_lockstep_pipe: directed and random checks of alu_lockstep_pipe against a behavioural model
module tb_alu_lockstep_pipe;
  localparam int W = 4;
  localparam int M = 15;
  logic clk = 0, rst = 1, in_valid = 0, lockstep = 0, fault_inj = 0, clr_err = 0;
  logic [W-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [2:0] sel0 = 0, sel1 = 0;
  logic ov, c0, c1, cd, mm, es;
  logic [W-1:0] o0, o1, df;
  logic [7:0] ec;
  logic ov2, c02, c12, cd2, mm2, es2;
  logic [W-1:0] o02, o12, df2;
  logic [1:0] ec2;
  int total = 0, bad = 0;
  bit chk_on = 0;

  alu_lockstep_pipe #(.WIDTH(W), .CNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .sel0(sel0), .sel1(sel1), .lockstep(lockstep), .fault_inj(fault_inj), .clr_err(clr_err),
    .out_valid(ov), .alu_out0(o0), .alu_out1(o1), .carry0(c0), .carry1(c1), .diff(df),
    .carry_diff(cd), .mismatch(mm), .err_sticky(es), .err_count(ec));

  alu_lockstep_pipe #(.WIDTH(W), .CNT_W(2)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .sel0(sel0), .sel1(sel1), .lockstep(lockstep), .fault_inj(fault_inj), .clr_err(clr_err),
    .out_valid(ov2), .alu_out0(o02), .alu_out1(o12), .carry0(c02), .carry1(c12), .diff(df2),
    .carry_diff(cd2), .mismatch(mm2), .err_sticky(es2), .err_count(ec2));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int alu_m(input int a, input int b, input int op, output int c);
    c = 0;
    case (op)
      0: begin c = (a + b) > M; return (a + b) & M; end
      1: begin c = a < b; return (a - b) & M; end
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: begin c = (a >> (W - 1)) & 1; return (a << 1) & M; end
      6: begin c = a & 1; return a >> 1; end
      default: begin c = a < b; return a < b ? b : a; end
    endcase
  endfunction

  int m_o0, m_o1, m_c0, m_c1, m_d, m_cd, m_ov, m_mm, m_es, m_ec, m_ec2;
  int s_a0, s_b0, s_s0, s_a1, s_b1, s_s1, s_fi, s_ls, s_v;

  always @(posedge clk) begin
    if (rst) begin
      {m_o0, m_o1, m_c0, m_c1, m_d, m_cd, m_ov, m_mm, m_es, m_ec, m_ec2, s_v} = '0;
    end else begin
      if (clr_err) begin
        m_es = 0; m_ec = 0; m_ec2 = 0;
      end else if (m_mm != 0) begin
        m_es = 1;
        m_ec = m_ec < 255 ? m_ec + 1 : 255;
        m_ec2 = m_ec2 < 3 ? m_ec2 + 1 : 3;
      end
      m_ov = s_v;
      m_mm = 0;
      if (s_v != 0) begin
        m_o0 = alu_m(s_a0, s_b0, s_s0, m_c0);
        m_o1 = alu_m(s_a1, s_b1, s_s1, m_c1) ^ s_fi;
        m_d = m_o0 ^ m_o1;
        m_cd = m_c0 ^ m_c1;
        m_mm = (s_ls != 0 && (m_d != 0 || m_cd != 0)) ? 1 : 0;
      end
      s_v = in_valid;
      if (in_valid) begin
        s_a0 = a0; s_b0 = b0; s_s0 = sel0; s_fi = fault_inj; s_ls = lockstep;
        s_a1 = lockstep ? a0 : a1;
        s_b1 = lockstep ? b0 : b1;
        s_s1 = lockstep ? sel0 : sel1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", ov, m_ov);
      chk("alu_out0", o0, m_o0);
      chk("alu_out1", o1, m_o1);
      chk("carry0", c0, m_c0);
      chk("carry1", c1, m_c1);
      chk("diff", df, m_d);
      chk("carry_diff", cd, m_cd);
      chk("mismatch", mm, m_mm);
      chk("err_sticky", es, m_es);
      chk("err_count", ec, m_ec);
      chk("err_sticky_c2", es2, m_es);
      chk("err_count_c2", ec2, m_ec2);
    end
  end

  initial begin
    int exp_c2 [5];
    exp_c2 = '{1, 2, 3, 3, 3};
    step();
    step();
    chk_on = 1;
    chk("rst_ov", ov, 0);
    chk("rst_out0", o0, 0);
    chk("rst_cnt", ec, 0);
    rst = 0;
    a0 = 9; b0 = 8; sel0 = 0; a1 = 3; b1 = 5; sel1 = 1; lockstep = 0; in_valid = 1;
    step();
    in_valid = 0;
    chk("t1_early_ov", ov, 0);
    step();
    chk("t1_ov", ov, 1);
    chk("t1_out0", o0, 4'h1);
    chk("t1_c0", c0, 1);
    chk("t1_out1", o1, 4'hE);
    chk("t1_c1", c1, 1);
    chk("t1_diff", df, 4'hF);
    chk("t1_cd", cd, 0);
    chk("t1_mm", mm, 0);
    step();
    chk("t1_ov_drop", ov, 0);
    lockstep = 1;
    for (int i = 0; i < 9; i++) begin
      in_valid = i < 8;
      a0 = 4'hA; b0 = 4'h5; sel0 = 3'(i);
      a1 = 4'($urandom); b1 = 4'($urandom); sel1 = 3'($urandom);
      step();
      if (i >= 1) begin
        chk("ls_ov", ov, 1);
        chk("ls_eq", o1, o0);
        chk("ls_diff", df, 0);
        chk("ls_mm", mm, 0);
        if (i - 1 == 5) begin
          chk("ls_shl_out", o0, 4'h4);
          chk("ls_shl_c", c0, 1);
        end
        if (i - 1 == 7) begin
          chk("ls_max_out", o0, 4'hA);
          chk("ls_max_c", c0, 0);
        end
      end
    end
    in_valid = 0;
    step();
    a0 = 3; b0 = 3; sel0 = 4; fault_inj = 1; in_valid = 1;
    step();
    in_valid = 0; fault_inj = 0;
    step();
    chk("f_out0", o0, 0);
    chk("f_out1", o1, 1);
    chk("f_diff", df, 1);
    chk("f_mm", mm, 1);
    step();
    chk("f_sticky", es, 1);
    chk("f_cnt", ec, 1);
    step();
    chk("f_sticky_hold", es, 1);
    chk("f_cnt_hold", ec, 1);
    clr_err = 1;
    step();
    clr_err = 0;
    for (int i = 0; i < 5; i++) begin
      a0 = 4'($urandom); b0 = 4'($urandom); sel0 = 3'($urandom); fault_inj = 1; in_valid = 1;
      step();
      in_valid = 0; fault_inj = 0;
      step();
      step();
      chk("sat_cnt", ec2, exp_c2[i]);
    end
    a0 = 1; b0 = 2; sel0 = 0; fault_inj = 1; in_valid = 1;
    step();
    in_valid = 0; fault_inj = 0;
    step();
    clr_err = 1;
    chk("clr_mm", mm, 1);
    step();
    clr_err = 0;
    chk("clr_cnt2", ec2, 0);
    chk("clr_sticky2", es2, 0);
    chk("clr_cnt", ec, 0);
    lockstep = 0; a0 = 1; b0 = 2; sel0 = 0; in_valid = 1;
    step();
    in_valid = 0; rst = 1;
    step();
    rst = 0;
    chk("rst_mid_ov", ov, 0);
    chk("rst_mid_out0", o0, 0);
    chk("rst_mid_sticky", es, 0);
    step();
    chk("rst_after_ov", ov, 0);
    step();
    chk("rst_after_ov2", ov, 0);
    a0 = 6; b0 = 7; sel0 = 0; in_valid = 1;
    step();
    in_valid = 0;
    step();
    chk("post_rst_ov", ov, 1);
    chk("post_rst_out0", o0, 4'hD);
    chk("post_rst_c0", c0, 0);
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 4) != 0;
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      sel0 = 3'($urandom); sel1 = 3'($urandom);
      lockstep = 1'($urandom);
      fault_inj = ($urandom % 6) == 0;
      clr_err = ($urandom % 40) == 0;
      rst = ($urandom % 120) == 0;
      step();
    end
    in_valid = 0; rst = 0; clr_err = 0;
    step();
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_lockstep_pipe.md
Name: alu_lockstep_pipe

Overview:
- Parametrised, pipelined successor to the dual 4-bit XOR-compared ALU pair.
- Two WIDTH-bit ALU lanes with an 8-op set, 2-stage registered pipeline with valid tracking.
- Lane-result XOR comparator, per-cycle mismatch pulse, sticky error flag, saturating mismatch counter.
- Lockstep mode ties lane 1 to lane 0's operands. Sits inside the user project wrapper, driven from io_in/LA and observed on io_out/LA.

Parameters:
- WIDTH, 4, operand/result width per lane (>=2).
- CNT_W, 8, mismatch counter width (>=1).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- in_valid  in  1  operand set present this cycle.
- a0, b0  in  WIDTH  lane 0 operands.
- a1, b1  in  WIDTH  lane 1 operands.
- sel0, sel1  in  3  lane op selects.
- lockstep  in  1  1 = lane 1 uses a0/b0/sel0 and mismatches are logged.
- fault_inj  in  1  sampled with in_valid; inverts bit 0 of lane 1 result.
- clr_err  in  1  clears err_sticky and err_count.
- out_valid  out  1  result registers hold valid data.
- alu_out0, alu_out1  out  WIDTH  lane results.
- carry0, carry1  out  1  lane carry/flag.
- diff  out  WIDTH  alu_out0 ^ alu_out1.
- carry_diff  out  1  carry0 ^ carry1.
- mismatch  out  1  single-cycle mismatch pulse.
- err_sticky  out  1  latched mismatch.
- err_count  out  CNT_W  saturating mismatch count.

Behaviour:
- Reset: all outputs 0; both stage valids 0; the wb_rst_i cycle dominates every other input.
- Stage 1, on in_valid: registers operands, selects, fault_inj and the lockstep-muxed lane 1 inputs. When in_valid=0, the stage-1 valid clears and operand registers hold.
- Stage 2: computes both lanes and registers results, carries, diff and carry_diff; out_valid = delayed stage-1 valid.
- Latency: exactly 2 cycles from in_valid to out_valid. Throughput 1/cycle; no backpressure.
- Outputs hold their last value while out_valid=0.
- Ops (unsigned, WIDTH-bit, carry as stated):
  - 000 add: {carry,out} = a+b.
  - 001 sub: out = a-b mod 2^WIDTH; carry = borrow (a<b).
  - 010 and, 011 or, 100 xor: carry 0.
  - 101 shl1: out = a<<1; carry = a[MSB].
  - 110 shr1: out = a>>1; carry = a[0].
  - 111 max: out = max(a,b); carry = (a<b).
- fault_inj: applied after the lane 1 computation, before registering. It affects alu_out1 and diff, not carry1.
- mismatch: pulses 1 in the same cycle as out_valid when lockstep (as sampled with that operand set) = 1, out_valid = 1 and (diff != 0 or carry_diff = 1). Otherwise 0. With lockstep=0, diff and carry_diff are still produced but never flagged.
- err_sticky: sets on mismatch. Cleared only by clr_err or reset.
- err_count:
  - Increments by 1 per mismatch and saturates at 2^CNT_W-1; no wrap.
  - clr_err in the same cycle as a mismatch: clear wins. Sticky and count go to 0 and that mismatch is not counted; the mismatch pulse is still output.
- Changing lockstep mid-stream takes effect only for operand sets sampled afterwards. In-flight sets keep their own sampled mode.
- Reset mid-operation: in-flight sets are discarded. No out_valid appears for them after reset deasserts.

Test Plan:
- WIDTH=4, lockstep=0: lane 0 add 9+8, lane 1 sub 3-5, in_valid 1 cycle -> 2 cycles later out_valid=1 for 1 cycle, with:
  - alu_out0=0x1, carry0=1; alu_out1=0xE, carry1=1.
  - diff=0xF, carry_diff=0, mismatch=0.
- lockstep=1, 8 back-to-back sets covering all sel values with a0=0xA, b0=0x5 -> out_valid high for 8 consecutive cycles, alu_out1==alu_out0 each cycle, diff=0, mismatch never asserted. Spot checks:
  - shl1 -> out 0x4, carry 1.
  - max -> out 0xA, carry 0.
- lockstep=1, fault_inj=1 on one set (xor 0x3^0x3) -> alu_out0=0x0, alu_out1=0x1, diff=0x1, mismatch pulse, err_sticky=1, err_count=1. Both persist afterwards.
- CNT_W=2 override, 5 faulted lockstep sets -> err_count reads 1,2,3,3,3. Then clr_err coincident with a 6th mismatch -> mismatch=1 that cycle, next cycle err_count=0, err_sticky=0.
- Assert wb_rst_i for 1 cycle, one cycle after an in_valid -> no out_valid follows; all outputs 0. A new set issued after reset returns normally with 2-cycle latency.
